// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module   : stream_rr_arbiter
// Purpose  : Round-robin N:1 valid/ready stream arbiter with burst-locked
//            grants and a registered output stage.
// Options  : STREAM_ARB_TIMEOUT_EN enables forced release of an idle grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_rr_arbiter #(
    parameter  int NUM     = 4,
    parameter  int WIDTH   = 8,
    parameter  int BEATS   = 4,
    parameter  int TIMEOUT = 16,
    localparam int IDXW    = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [NUM-1:0]         iValid_AM,
    output logic [NUM-1:0]         oReady_AM,
    input  logic [NUM*WIDTH-1:0]   iData_AM,
    output logic                   oValid_BM,
    input  logic                   iReady_BM,
    output logic [WIDTH-1:0]       oData_BM,
    output logic [IDXW-1:0]        oSrc_BM,
    output logic                   oBusy
);

    localparam int CW = $clog2(BEATS + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   grant;
    logic [CW-1:0]     cnt;

    logic [NUM-1:0]    hi_req;
    logic [IDXW-1:0]   pick_lo;
    logic [IDXW-1:0]   pick_hi;
    logic [IDXW-1:0]   pick;
    logic [IDXW-1:0]   next_ptr;
    logic              sel_valid;
    logic [WIDTH-1:0]  sel_data;
    logic              out_free;
    logic              in_hs;

    if (NUM < 1 || BEATS < 1 || TIMEOUT < 1) begin : g_param_check
        $error("stream_rr_arbiter: NUM, BEATS and TIMEOUT must all be >= 1");
    end

`ifdef STREAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     idle_cnt;
`endif

    // Rotating priority: lowest requester at or above ptr wins, else wrap to the lowest overall.
    always_comb begin
        hi_req  = '0;
        pick_lo = '0;
        pick_hi = '0;
        for (int i = 0; i < NUM; i++) begin
            hi_req[i] = iValid_AM[i] && (i >= int'(ptr));
        end
        for (int i = NUM - 1; i >= 0; i--) begin
            if (iValid_AM[i]) pick_lo = IDXW'(i);
            if (hi_req[i])    pick_hi = IDXW'(i);
        end
        pick = (|hi_req) ? pick_hi : pick_lo;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (grant == IDXW'(i)) begin
                sel_valid = iValid_AM[i];
                sel_data  = iData_AM[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr = (grant == IDXW'(NUM - 1)) ? '0 : grant + IDXW'(1);
    assign out_free = !oValid_BM || iReady_BM;
    assign in_hs    = (state == ST_LOCK) && sel_valid && out_free;
    assign oBusy    = (state == ST_LOCK);

    always_comb begin
        oReady_AM = '0;
        if (state == ST_LOCK) begin
            for (int i = 0; i < NUM; i++) begin
                oReady_AM[i] = (grant == IDXW'(i)) && out_free;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant     <= '0;
            cnt       <= '0;
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
            oSrc_BM   <= '0;
`ifdef STREAM_ARB_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else begin
            // Output register reloads on a new beat even when the old one leaves this same edge.
            if (in_hs) begin
                oData_BM  <= sel_data;
                oSrc_BM   <= grant;
                oValid_BM <= 1'b1;
            end else if (oValid_BM && iReady_BM) begin
                oValid_BM <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (|iValid_AM) begin
                        grant    <= pick;
                        cnt      <= '0;
                        state    <= ST_LOCK;
`ifdef STREAM_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                ST_LOCK: begin
                    if (in_hs) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(BEATS - 1)) begin
                            state <= ST_IDLE;
                            ptr   <= next_ptr;
                        end
                    end
`ifdef STREAM_ARB_TIMEOUT_EN
                    if (sel_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        idle_cnt <= '0;
                        state    <= ST_IDLE;
                        ptr      <= next_ptr;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Purpose  : Directed self-checking bench for stream_rr_arbiter (NUM=4, BEATS=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid;
    logic [3:0]  rdy;
    logic [31:0] data;
    logic        ovalid;
    logic        oready = 1'b1;
    logic [7:0]  odata;
    logic [1:0]  osrc;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          cons [4] = '{0, 0, 0, 0};
    int          lim  [4] = '{0, 0, 0, 0};
    logic [7:0]  base [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [9:0]  q [$];
    int          tq [$];

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM(4), .WIDTH(8), .BEATS(4), .TIMEOUT(16)) dut (
        .iCLK      (clk),
        .iRST      (rst_n),
        .iValid_AM (valid),
        .oReady_AM (rdy),
        .iData_AM  (data),
        .oValid_BM (ovalid),
        .iReady_BM (oready),
        .oData_BM  (odata),
        .oSrc_BM   (osrc),
        .oBusy     (busy)
    );

    // Each source offers beats base+cons while cons < lim.
    for (genvar g = 0; g < 4; g++) begin : g_src
        assign valid[g]          = (cons[g] < lim[g]);
        assign data[g*8 +: 8]    = base[g] + cons[g][7:0];
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (ovalid && oready) begin
                q.push_back({osrc, odata});
                tq.push_back(cyc);
            end
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && rdy[i]) cons[i] <= cons[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic give(input int i, input int n, input logic [7:0] d0);
        lim[i]  = cons[i] + n;
        base[i] = d0 - cons[i][7:0];
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k;
        k = 0;
        while (q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, q.size(), n);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, ovalid, 1'b0);
        chk({tag, "_data"},  odata,  8'h00);
        chk({tag, "_src"},   osrc,   2'd0);
        chk({tag, "_ready"}, rdy,    4'b0000);
        chk({tag, "_busy"},  busy,   1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // All four sources busy: 0x8 (two grants), 1x4, 2x4, 3x4 in round-robin order.
        give(0, 8, 8'h00);
        give(1, 4, 8'h10);
        give(2, 4, 8'h20);
        give(3, 4, 8'h30);
        wait_beats(20, "rr_count");
        for (int k = 0; k < 20; k++) begin
            chk("rr_src",  q[k][9:8], (k / 4) % 4);
            chk("rr_data", q[k][7:0], ((k / 4) % 4) * 16 + ((k >= 16) ? 4 : 0) + k % 4);
            chk("rr_time", tq[k] - tq[0], 5 * (k / 4) + k % 4);
        end
        chk("rr_end_busy",  busy,   1'b0);
        chk("rr_end_valid", ovalid, 1'b0);

        // Single requester keeps winning; ptr=1 at start.
        q.delete(); tq.delete();
        give(2, 8, 8'hA0);
        wait_beats(8, "solo_count");
        for (int k = 0; k < 8; k++) begin
            chk("solo_src",  q[k][9:8], 2'd2);
            chk("solo_data", q[k][7:0], 8'hA0 + k);
        end
        chk("solo_bubble", tq[4] - tq[3], 2);

        // Backpressure mid-burst; ptr=3 so input 1 wins after wrapping.
        q.delete(); tq.delete();
        give(1, 4, 8'h50);
        wait_beats(1, "bp_first");
        oready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", ovalid, 1'b1);
            chk("bp_data",  odata,  8'h51);
            chk("bp_src",   osrc,   2'd1);
            chk("bp_ready", rdy,    4'b0000);
        end
        oready = 1'b1;
        wait_beats(4, "bp_count");
        repeat (3) @(negedge clk);
        chk("bp_nodup", q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_seq", q[k], {2'd1, 8'h50 + 8'(k)});
        end

        // Move ptr to 3, then inputs 0 and 3 compete: 3 first, then 0.
        give(2, 4, 8'h60);
        wait_beats(8, "wrap_prep");
        q.delete(); tq.delete();
        give(0, 4, 8'h70);
        give(3, 4, 8'h80);
        wait_beats(8, "wrap_count");
        for (int k = 0; k < 4; k++) begin
            chk("wrap_first",  q[k],     {2'd3, 8'h80 + 8'(k)});
            chk("wrap_second", q[k + 4], {2'd0, 8'h70 + 8'(k)});
        end

        // ptr=1 now; with 1 and 2 idle, 3 beats 0.
        q.delete(); tq.delete();
        give(0, 4, 8'h90);
        give(3, 4, 8'hC0);
        wait_beats(8, "ptr1_count");
        for (int k = 0; k < 4; k++) begin
            chk("ptr1_first",  q[k],     {2'd3, 8'hC0 + 8'(k)});
            chk("ptr1_second", q[k + 4], {2'd0, 8'h90 + 8'(k)});
        end

`ifdef STREAM_ARB_TIMEOUT_EN
        // Input 1 stalls after one beat; grant is force-released after 16 idle cycles.
        q.delete(); tq.delete();
        give(1, 1, 8'hD0);
        give(2, 1, 8'hE0);
        wait_beats(2, "tmo_count");
        chk("tmo_first",  q[0], {2'd1, 8'hD0});
        chk("tmo_second", q[1], {2'd2, 8'hE0});
        chk("tmo_gap",    tq[1] - tq[0], 18);
`endif

        // Asynchronous reset in the middle of a burst.
        q.delete(); tq.delete();
        give(1, 8, 8'hF0);
        wait_beats(2, "arst_pre_count");
        chk("arst_pre_valid", ovalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("arst");
        @(negedge clk);
        chk_idle_outputs("arst_hold");
        give(0, 1, 8'h11);
        q.delete(); tq.delete();
        rst_n = 1'b1;
        wait_beats(1, "arst_regrant");
        chk("arst_first_grant", q[0], {2'd0, 8'h11});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
